// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - IF/MEM arbiter in front of a single-port unified memory
//
// Purpose: arbitrates the fetch stage (if_*) and the memory stage (dm_*) onto one
// backing memory port (mem_*) using a req/gnt/rvalid handshake. One transaction is
// in flight at a time; completion is reported as a one-cycle ready pulse to the
// owner, with combinational stall outputs for the hazard unit. A response watchdog
// aborts transactions that spend TIMEOUT_CYCLES in ISSUE+WAIT (0 disables it).
//
// Optional build macro: MEM_ARB_RR_EN
//   defined   - round-robin between IF and MEM when both request together
//   undefined - MEM always wins over IF
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   if_req/if_addr                   fetch request and address (held until if_ready)
//   if_rdata/if_ready/if_stall       fetched word, completion pulse, stall
//   dm_req/dm_we/dm_addr/dm_wdata    data request (held until dm_ready)
//   dm_rdata/dm_ready/dm_stall       load data, completion pulse, stall
//   mem_req/mem_we/mem_addr/mem_wdata  request to backing memory
//   mem_gnt/mem_rvalid/mem_rdata     accept, response/ack, read data
//   err                              watchdog abort flag, valid with ready
module unified_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    // Counter holds 0..TIMEOUT_CYCLES-1; the abort fires on the last of those cycles.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arbState_e;

    arbState_e         state;
    arbState_e         nextState;
    logic              ownerDm;
    logic [ADDR_W-1:0] addrQ;
    logic              weQ;
    logic [DATA_W-1:0] wdataQ;
    logic [CNT_W-1:0]  waitCnt;
    logic              abortQ;
    logic [DATA_W-1:0] ifRdataQ;
    logic [DATA_W-1:0] dmRdataQ;

    logic takeDm;
    logic timeoutHit;
    logic respNow;
    logic abortNow;

`ifdef MEM_ARB_RR_EN
    logic lastOwnerDm;

    // With both pending, hand the grant to whichever port did not win last time.
    assign takeDm = dm_req & (~if_req | ~lastOwnerDm);
`else
    assign takeDm = dm_req;
`endif

    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (waitCnt == CNT_LAST);
    assign respNow    = (state == WAIT) && mem_rvalid;
    // A response in the final WAIT cycle still counts as on time; a grant
    // arriving in the final ISSUE cycle does not save the transaction.
    assign abortNow   = timeoutHit && ((state == ISSUE) || ((state == WAIT) && !mem_rvalid));

    always_comb begin
        nextState = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ready  = 1'b0;
        dm_ready  = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req || if_req) begin
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                mem_req   = 1'b1;
                mem_we    = weQ;
                mem_addr  = addrQ;
                mem_wdata = wdataQ;
                if (abortNow) begin
                    nextState = DONE;
                end else if (mem_gnt) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (respNow || abortNow) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if_ready  = ~ownerDm;
                dm_ready  = ownerDm;
                err       = abortQ;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ownerDm  <= 1'b0;
            addrQ    <= '0;
            weQ      <= 1'b0;
            wdataQ   <= '0;
            waitCnt  <= '0;
            abortQ   <= 1'b0;
            ifRdataQ <= '0;
            dmRdataQ <= '0;
`ifdef MEM_ARB_RR_EN
            lastOwnerDm <= 1'b0;
`endif
        end else begin
            state <= nextState;
            if ((state == IDLE) && (dm_req || if_req)) begin
                ownerDm <= takeDm;
                addrQ   <= takeDm ? dm_addr : if_addr;
                weQ     <= takeDm & dm_we;
                wdataQ  <= takeDm ? dm_wdata : '0;
                waitCnt <= '0;
                abortQ  <= 1'b0;
`ifdef MEM_ARB_RR_EN
                lastOwnerDm <= takeDm;
`endif
            end
            if ((state == ISSUE) || (state == WAIT)) begin
                waitCnt <= waitCnt + CNT_W'(1);
            end
            if (respNow) begin
                if (ownerDm) begin
                    dmRdataQ <= weQ ? '0 : mem_rdata;
                end else begin
                    ifRdataQ <= mem_rdata;
                end
            end
            if (abortNow) begin
                abortQ <= 1'b1;
                if (ownerDm) begin
                    dmRdataQ <= '0;
                end else begin
                    ifRdataQ <= '0;
                end
            end
        end
    end

    assign if_rdata = ifRdataQ;
    assign dm_rdata = dmRdataQ;
    assign if_stall = if_req & ~if_ready;
    assign dm_stall = dm_req & ~dm_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Backing-memory responder state and configuration
    logic [31:0] backMem [0:63];
    int          cfgG    = 0;
    int          cfgR    = 0;
    bit          cfgRand = 1'b0;
    bit          cfgNoRv = 1'b0;
    int          injReq  = 0;
    int          injSeen = 0;
    int          gntCount = 0;
    logic [64:0] issuedQ [$];
    bit          rBusy = 1'b0;
    bit          rGranted = 1'b0;
    int          gw = 0;
    int          rw = 0;
    logic        cWe = 1'b0;
    logic [31:0] cAddr = '0;
    logic [31:0] cWd = '0;

    unified_mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_rdata(if_rdata),
        .if_ready(if_ready),
        .if_stall(if_stall),
        .dm_req(dm_req),
        .dm_we(dm_we),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata),
        .dm_ready(dm_ready),
        .dm_stall(dm_stall),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    // Memory model: acts at posedge+1, the main thread acts at posedge+2.
    initial begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (reset) begin
                rBusy = 1'b0;
                rGranted = 1'b0;
            end else if (injSeen != injReq) begin
                injSeen = injReq;
                mem_rvalid = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end else begin
                if (!rBusy && mem_req) begin
                    rBusy = 1'b1;
                    rGranted = 1'b0;
                    gw = cfgRand ? int'($urandom_range(3, 0)) : cfgG;
                    rw = cfgRand ? int'($urandom_range(2, 0)) : cfgR;
                end
                if (rBusy && !rGranted) begin
                    if (!mem_req) begin
                        rBusy = 1'b0;
                    end else if (gw == 0) begin
                        mem_gnt = 1'b1;
                        rGranted = 1'b1;
                        cWe = mem_we;
                        cAddr = mem_addr;
                        cWd = mem_wdata;
                        issuedQ.push_back({cWe, cAddr, cWd});
                        gntCount++;
                    end else begin
                        gw--;
                    end
                end else if (rBusy && rGranted) begin
                    if (rw == 0) begin
                        rBusy = 1'b0;
                        if (!cfgNoRv) begin
                            mem_rvalid = 1'b1;
                            if (cWe) begin
                                backMem[cAddr[7:2]] = cWd;
                                mem_rdata = $urandom;
                            end else begin
                                mem_rdata = backMem[cAddr[7:2]];
                            end
                        end
                    end else begin
                        rw--;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        tick();
        tick();
        checks++;
        if ({if_ready, if_stall, dm_ready, dm_stall, mem_req, mem_we, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {if_ready, if_stall, dm_ready, dm_stall, mem_req, mem_we, err});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({if_ready, dm_ready, mem_req, err} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 0000", {if_ready, dm_ready, mem_req, err});
        end
    endtask

    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({if_stall, dm_stall} !== 2'b11) begin
            errors++;
            $display("FAIL sim_stalls got %b want 11", {if_stall, dm_stall});
        end
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h40, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL sim_first_issue got %h want %h",
                     {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h40, 32'hDEADBEEF});
        end
        tick();
        tick();
        checks++;
        if ({dm_ready, if_ready, dm_stall, if_stall} !== 4'b1001 || dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL sim_dm_done got %b/%h want 1001/0",
                     {dm_ready, if_ready, dm_stall, if_stall}, dm_rdata);
        end
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b10, 32'h10, 32'h0}) begin
            errors++;
            $display("FAIL sim_second_issue got %h want %h",
                     {mem_req, mem_we, mem_addr, mem_wdata}, {2'b10, 32'h10, 32'h0});
        end
        tick();
        tick();
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h00500093) begin
            errors++;
            $display("FAIL sim_if_done got %b/%h want 1/00500093", if_ready, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_fetch_read();
        cfgG = 0; cfgR = 0; cfgNoRv = 1'b0;
        if_addr = 32'h10; if_req = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) tick(); else #1;
            checks++;
            if (if_ready !== 1'(c == 3) || if_stall !== 1'(c != 3)) begin
                errors++;
                $display("FAIL fetch_cycle%0d got ready=%b stall=%b want %b/%b",
                         c, if_ready, if_stall, c == 3, c != 3);
            end
        end
        checks++;
        if (if_rdata !== 32'h00500093) begin
            errors++;
            $display("FAIL fetch_rdata got %h want 00500093", if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        cfgG = 5;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_wdata = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom);
            #1;
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b10, 32'h80, 32'h0}) begin
                errors++;
                $display("FAIL bp_hold_c%0d got %h want %h", c,
                         {mem_req, mem_we, mem_addr, mem_wdata}, {2'b10, 32'h80, 32'h0});
            end
        end
        tick();
        checks++;
        if ({mem_req, dm_ready} !== 2'b00) begin
            errors++;
            $display("FAIL bp_wait got %b want 00", {mem_req, dm_ready});
        end
        tick();
        checks++;
        if (dm_ready !== 1'b1 || dm_rdata !== 32'h12345678 || err !== 1'b0) begin
            errors++;
            $display("FAIL bp_done got %b/%h/%b want 1/12345678/0", dm_ready, dm_rdata, err);
        end
        dm_req = 1'b0; dm_we = 1'b0;
        cfgG = 0;
        tick();
    endtask

    task automatic test_watchdog();
        cfgNoRv = 1'b1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h84;
        for (int c = 1; c <= 9; c++) begin
            tick();
            checks++;
            if ({dm_ready, err} !== {1'(c == 9), 1'(c == 9)}) begin
                errors++;
                $display("FAIL wd_c%0d got ready/err=%b want %b", c, {dm_ready, err},
                         {1'(c == 9), 1'(c == 9)});
            end
        end
        checks++;
        if (dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wd_rdata got %h want 0", dm_rdata);
        end
        dm_req = 1'b0;
        tick();
        checks++;
        if ({mem_req, dm_ready, err} !== 3'b000) begin
            errors++;
            $display("FAIL wd_idle got %b want 000", {mem_req, dm_ready, err});
        end
    endtask

    task automatic test_reset_wait();
        cfgNoRv = 1'b1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        tick();
        tick();
        reset = 1'b1; dm_req = 1'b0;
        tick();
        checks++;
        if ({if_ready, if_stall, dm_ready, dm_stall, mem_req, mem_we, err} !== 7'b0 ||
            {mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'b0) begin
            errors++;
            $display("FAIL rst_wait_outputs got %b/%h want 0/0",
                     {if_ready, if_stall, dm_ready, dm_stall, mem_req, mem_we, err},
                     {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        reset = 1'b0;
        tick();
        injReq++;
        for (int c = 5; c <= 8; c++) begin
            tick();
            checks++;
            if ({if_ready, dm_ready, err, mem_req} !== 4'b0) begin
                errors++;
                $display("FAIL late_rvalid_c%0d got %b want 0000", c,
                         {if_ready, dm_ready, err, mem_req});
            end
        end
        cfgNoRv = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        tick();
        tick();
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h00500093) begin
            errors++;
            $display("FAIL rst_recover got %b/%h want 1/00500093", if_ready, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_held();
        int gStart;
        int readies;
        gStart = gntCount;
        readies = 0;
        cfgG = 0; cfgR = 0; cfgNoRv = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) tick(); else #1;
            if (dm_ready === 1'b1) readies++;
            checks++;
            if ({dm_ready, mem_req} !== {1'((c % 4) == 3), 1'((c % 4) == 1)}) begin
                errors++;
                $display("FAIL held_c%0d got ready/req=%b want %b", c, {dm_ready, mem_req},
                         {1'((c % 4) == 3), 1'((c % 4) == 1)});
            end
        end
        dm_req = 1'b0;
        tick();
        checks++;
        if ((gntCount - gStart) != 3 || readies != 3) begin
            errors++;
            $display("FAIL held_count got grants=%0d readies=%0d want 3/3",
                     gntCount - gStart, readies);
        end
    endtask

    task automatic test_random();
        bit          ifOn, dmOn, busyM, pickDm, pickWe, lastDm, prevRv, doneNow, expIfR, expDmR;
        logic [31:0] pickAddr, pickWd, expIfRd, expDmRd, prevRd;
        logic [64:0] ent;
        int          completions;
        ifOn = 0; dmOn = 0; busyM = 0; pickDm = 0; pickWe = 0; lastDm = 0; prevRv = 0;
        pickAddr = '0; pickWd = '0; expIfRd = '0; expDmRd = '0; prevRd = '0;
        completions = 0;
        if_req = 1'b0; dm_req = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        issuedQ.delete();
        cfgRand = 1'b1;
        for (int n = 0; n < 600; n++) begin
            tick();
            // A transaction finishes the cycle after its response arrived.
            doneNow = busyM && prevRv;
            expIfR = doneNow && !pickDm;
            expDmR = doneNow && pickDm;
            if (doneNow) begin
                if (pickDm) expDmRd = pickWe ? 32'h0 : prevRd;
                else expIfRd = prevRd;
            end
            checks++;
            if ({if_ready, dm_ready, err, if_stall, dm_stall} !==
                {expIfR, expDmR, 1'b0, ifOn && !expIfR, dmOn && !expDmR}) begin
                errors++;
                $display("FAIL rnd_ctrl_n%0d got %b want %b", n,
                         {if_ready, dm_ready, err, if_stall, dm_stall},
                         {expIfR, expDmR, 1'b0, ifOn && !expIfR, dmOn && !expDmR});
            end
            checks++;
            if (if_rdata !== expIfRd || dm_rdata !== expDmRd) begin
                errors++;
                $display("FAIL rnd_rdata_n%0d got %h/%h want %h/%h", n,
                         if_rdata, dm_rdata, expIfRd, expDmRd);
            end
            if (doneNow) begin
                completions++;
                checks++;
                if (issuedQ.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_issue_n%0d got none want %h", n, {pickWe, pickAddr, pickWd});
                end else begin
                    ent = issuedQ.pop_front();
                    if (ent !== {pickWe, pickAddr, pickWd}) begin
                        errors++;
                        $display("FAIL rnd_issue_n%0d got %h want %h", n, ent,
                                 {pickWe, pickAddr, pickWd});
                    end
                end
                busyM = 0;
                if (pickDm) dmOn = 0; else ifOn = 0;
            end
            if (!ifOn && $urandom_range(1, 0) == 1) ifOn = 1;
            if (!dmOn && $urandom_range(1, 0) == 1) dmOn = 1;
            if_addr = {24'h0, 6'($urandom_range(63, 0)), 2'b00};
            dm_addr = {24'h0, 6'($urandom_range(63, 0)), 2'b00};
            dm_we = 1'($urandom);
            dm_wdata = $urandom;
            if_req = ifOn;
            dm_req = dmOn;
            if (!busyM && !doneNow && (ifOn || dmOn)) begin
                if (ifOn && dmOn) begin
`ifdef MEM_ARB_RR_EN
                    pickDm = !lastDm;
`else
                    pickDm = 1'b1;
`endif
                end else begin
                    pickDm = dmOn;
                end
                lastDm = pickDm;
                pickWe = pickDm && dm_we;
                pickAddr = pickDm ? dm_addr : if_addr;
                pickWd = pickDm ? dm_wdata : 32'h0;
                busyM = 1;
            end
            prevRv = mem_rvalid;
            prevRd = mem_rdata;
        end
        checks++;
        if (completions < 50) begin
            errors++;
            $display("FAIL rnd_progress got %0d want >=50", completions);
        end
        cfgRand = 1'b0;
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) backMem[i] = 32'h0;
        backMem[4]  = 32'h00500093;
        backMem[32] = 32'h12345678;
        backMem[33] = 32'hCAFEF00D;
        test_reset();
        test_simultaneous();
        test_fetch_read();
        test_backpressure();
        test_watchdog();
        test_reset_wait();
        test_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Arbitrates one single-port unified instruction/data memory between the fetch stage (IF) and the memory stage (MEM) of the 5-stage RISC-V pipeline. Each granted request is registered and issued to the backing memory with a req/gnt/rvalid handshake. The response is returned to the owner as a one-cycle ready pulse, and per-port stall outputs are generated for the hazard logic. A response watchdog aborts hung transactions.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT_CYCLES, 255, maximum cycles spent in ISSUE+WAIT before abort; 0 disables the watchdog

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_ready
if_addr  in  ADDR_W  fetch address (PCF)
if_rdata  out  DATA_W  fetched instruction, valid when if_ready=1
if_ready  out  1  one-cycle completion pulse for fetch
if_stall  out  1  fetch must hold (feeds StallF/StallD)
dm_req  in  1  data request; held until dm_ready
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data address (ALUResultM)
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, valid when dm_ready=1
dm_ready  out  1  one-cycle completion pulse for data
dm_stall  out  1  MEM stage must hold
mem_req  out  1  request to backing memory
mem_we  out  1  write enable to backing memory
mem_addr  out  ADDR_W  address to backing memory
mem_wdata  out  DATA_W  write data to backing memory
mem_gnt  in  1  memory accepts the request this cycle
mem_rvalid  in  1  response/ack; issued for both reads and writes
mem_rdata  in  DATA_W  read data
err  out  1  one-cycle pulse alongside ready when the transaction was aborted by the watchdog

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: FSM=IDLE, all outputs 0, latched addr/we/wdata/owner=0, wait counter=0. Reset mid-transaction abandons it; no ready is pulsed; a late mem_rvalid arriving after reset is ignored in IDLE.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample requests.
  - dm_req=1: latch owner=D, dm_addr, dm_we, dm_wdata.
  - else if_req=1: latch owner=I, if_addr, we=0, wdata=0.
  - Go to ISSUE. With no request, stay in IDLE.
- ISSUE: mem_req=1, with mem_we/addr/wdata taken from latched registers. Inputs changing after the latch have no effect. On mem_gnt go to WAIT; otherwise hold.
- WAIT: mem_req=0. On mem_rvalid, register mem_rdata into the owner's rdata (0 for writes) and go to DONE. mem_rvalid seen outside WAIT is ignored.
- DONE: owner's ready=1 for exactly this cycle, then return to IDLE. No sampling in DONE, so a held req is never re-issued.
- Minimum latency: req in cycle 0, ready in cycle 3 (gnt in cycle 1, rvalid in cycle 2).
- rdata outputs hold their value until the next completion for the same port.
- Stall outputs:
  - if_stall = if_req & ~if_ready
  - dm_stall = dm_req & ~dm_ready
  - Both are combinational, and both can be 1 together.
- Owner drops req mid-transaction: the transaction still completes and ready still pulses.
- Watchdog: the counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT. If it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), go to DONE with rdata=0 and err=1 alongside ready. mem_req drops on abort.
- Priority (base build): data always wins when both requests are pending in IDLE.

Optional Feature:
MEM_ARB_RR_EN
- Defined: a last_owner register (reset=I) is added. When both requests are pending in IDLE, the grant goes to the port not granted last; a single pending request is granted regardless.
- Undefined: fixed data-over-fetch priority; no last_owner register.

Test Plan:
1. Fetch read:
   - Stimulus: if_req=1, if_addr=0x10; gnt in cycle 1; rvalid in cycle 2 with rdata=0x00500093.
   - Required: if_ready=1 and if_rdata=0x00500093 in cycle 3; if_stall=1 in cycles 0-2.
2. Simultaneous requests:
   - Stimulus: if_req=1, dm_req=1 with dm_we=1, addr=0x40, wdata=0xDEADBEEF.
   - Required: mem_we=1, mem_addr=0x40 issued first; dm_ready pulses, then the fetch is issued. With MEM_ARB_RR_EN and last_owner=D, the fetch is issued first.
3. Grant backpressure:
   - Stimulus: mem_gnt low for 5 cycles; addr changes during ISSUE.
   - Required: mem_req and the latched mem_addr stay stable until gnt.
4. Watchdog:
   - Stimulus: TIMEOUT_CYCLES=8; gnt given, rvalid never arrives.
   - Required: dm_ready=1, err=1, dm_rdata=0 exactly 8 cycles after ISSUE entry; FSM back to IDLE.
5. Reset during WAIT, then late rvalid:
   - Required: no ready, all outputs 0; the next request completes normally.
6. Held request:
   - Stimulus: req kept high through DONE.
   - Required: exactly one mem_req issued per completed transaction; the new one starts in the cycle after DONE.
